// File: rtl/lsu_byte_seq.sv
// ---------------------------------------------------------------------------
// lsu_byte_seq
//
// Purpose:
//   CPU-side load/store initiator for a byte-organised data memory. A single
//   load or store from the MEM stage is broken into 1, 2 or 4 single-byte
//   accesses on a byte-wide memory port, little-endian (byte k of the word
//   lives at addr+k). Loads return a sign- or zero-extended result together
//   with a one-cycle done pulse.
//
// Ports:
//   clk        - single clock, all state updates on the rising edge
//   rst        - synchronous active-high reset
//   req        - request valid, accepted on an edge where req && ready
//   op         - MIPS opcode (lb/lh/lw/lbu/lhu/sb/sh/sw)
//   addr       - byte address, low ADDR_W bits used
//   wdata      - store data, low bytes used for sb/sh
//   ready      - high only while idle
//   done       - one-cycle completion pulse
//   err        - qualified by done: unsupported op or misaligned access
//   rdata      - load result, holds until the next completed load
//   mem_addr   - byte address to memory
//   mem_wdata  - byte to write
//   mem_we     - byte write enable, memory writes on the rising edge
//   mem_rdata  - combinational read data for mem_addr
// ---------------------------------------------------------------------------
module lsu_byte_seq #(
  parameter int ADDR_W      = 12,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [5:0]        op,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  // Opcode decode helpers shared by the accept path and the access path.
  function automatic logic op_valid(input logic [5:0] o);
    case (o)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: op_valid = 1'b1;
      default:                                                  op_valid = 1'b0;
    endcase
  endfunction

  function automatic logic op_store(input logic [5:0] o);
    case (o)
      OP_SB, OP_SH, OP_SW: op_store = 1'b1;
      default:             op_store = 1'b0;
    endcase
  endfunction

  // Index of the last byte of the access: 0 for byte, 1 for half, 3 for word.
  function automatic logic [1:0] op_last(input logic [5:0] o);
    case (o)
      OP_LH, OP_LHU, OP_SH: op_last = 2'd1;
      OP_LW, OP_SW:         op_last = 2'd3;
      default:              op_last = 2'd0;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [5:0] o, input logic [31:0] b);
    case (o)
      OP_LB:   extend = {{24{b[7]}}, b[7:0]};
      OP_LH:   extend = {{16{b[15]}}, b[15:0]};
      OP_LBU:  extend = {24'd0, b[7:0]};
      OP_LHU:  extend = {16'd0, b[15:0]};
      default: extend = b;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [5:0]          op_q, op_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [1:0]          last_q, last_d;
  logic [31:0]         ld_buf_q, ld_buf_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic                mem_we_q, mem_we_d;

  logic                in_valid;
  logic                in_store;
  logic [1:0]          in_last;
  logic                misaligned;
  logic [1:0]          cnt_inc;
  logic                unused_addr_hi;

  // Address bits above the memory width have no meaning here.
  assign unused_addr_hi = ^addr[31:ADDR_W];

  assign in_valid   = op_valid(op);
  assign in_store   = op_store(op);
  assign in_last    = op_last(op);
  assign misaligned = ALIGN_CHECK &&
                      (((in_last == 2'd1) && addr[0]) ||
                       ((in_last == 2'd3) && (addr[1:0] != 2'b00)));
  assign cnt_inc    = cnt_q + 2'd1;

  // Next-state logic. Memory-port outputs are registered, so each cycle
  // prepares the address/data/enable for the byte the next cycle will drive;
  // the first byte is therefore set up while accepting the request.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    ld_buf_d    = ld_buf_q;
    ready_d     = ready_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req && ready_q) begin
          op_d    = op;
          base_d  = addr[ADDR_W-1:0];
          wdata_d = wdata;
          cnt_d   = 2'd0;
          last_d  = in_last;
          ready_d = 1'b0;
          if (!in_valid || misaligned) begin
            // Rejected requests never touch the memory port.
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d     = S_ACCESS;
            mem_addr_d  = addr[ADDR_W-1:0];
            mem_wdata_d = wdata[7:0];
            mem_we_d    = in_store;
          end
        end
      end

      S_ACCESS: begin
        if (!op_store(op_q)) begin
          ld_buf_d[{cnt_q, 3'b000} +: 8] = mem_rdata;
        end
        if (cnt_q == last_q) begin
          // The final byte is merged from the live read data so the
          // extended result is ready in the done cycle.
          state_d = S_DONE;
          done_d  = 1'b1;
          if (!op_store(op_q)) begin
            rdata_d = extend(op_q, ld_buf_d);
          end
        end else begin
          cnt_d       = cnt_inc;
          mem_addr_d  = base_q + ADDR_W'(cnt_inc);
          mem_wdata_d = wdata_q[{cnt_inc, 3'b000} +: 8];
          mem_we_d    = op_store(op_q);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= 6'd0;
      base_q      <= '0;
      wdata_q     <= 32'd0;
      cnt_q       <= 2'd0;
      last_q      <= 2'd0;
      ld_buf_q    <= 32'd0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      ld_buf_q    <= ld_buf_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_lsu_byte_seq.sv
// ---------------------------------------------------------------------------
// tb_lsu_byte_seq
//
// Purpose:
//   Directed self-checking bench for lsu_byte_seq. Two instances share the
//   request fields: dut (alignment checking on) and dut_nc (alignment
//   checking off, used for the address-wrap case). Each has its own byte
//   memory model. Expected results are queued when a request is driven and
//   popped when the done pulse arrives.
// ---------------------------------------------------------------------------
module tb_lsu_byte_seq;

  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LH  = 6'b100001;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] LHU = 6'b100101;
  localparam logic [5:0] SB  = 6'b101000;
  localparam logic [5:0] SH  = 6'b101001;
  localparam logic [5:0] SW  = 6'b101011;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [5:0]  op;
  logic [31:0] addr, wdata;

  logic        ready0, done0, err0, mwe0;
  logic [31:0] rdata0;
  logic [11:0] maddr0;
  logic [7:0]  mwdata0, mrdata0;
  logic        ready1, done1, err1, mwe1;
  logic [31:0] rdata1;
  logic [11:0] maddr1;
  logic [7:0]  mwdata1, mrdata1;

  logic [7:0]  mem0 [0:4095];
  logic [7:0]  mem1 [0:4095];
  int          writes0 = 0;
  int          writes1 = 0;

  int          sel;
  logic        s_ready, s_done, s_err, s_we;
  logic [31:0] s_rdata;

  int          total = 0;
  int          bad = 0;
  exp_t        sb_q[$];

  always #5 clk = ~clk;

  lsu_byte_seq #(.ADDR_W(12), .ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst), .req(req0), .op(op), .addr(addr), .wdata(wdata),
    .ready(ready0), .done(done0), .err(err0), .rdata(rdata0),
    .mem_addr(maddr0), .mem_wdata(mwdata0), .mem_we(mwe0), .mem_rdata(mrdata0)
  );

  lsu_byte_seq #(.ADDR_W(12), .ALIGN_CHECK(1'b0)) dut_nc (
    .clk(clk), .rst(rst), .req(req1), .op(op), .addr(addr), .wdata(wdata),
    .ready(ready1), .done(done1), .err(err1), .rdata(rdata1),
    .mem_addr(maddr1), .mem_wdata(mwdata1), .mem_we(mwe1), .mem_rdata(mrdata1)
  );

  // Byte memories: combinational read, write on the rising edge.
  assign mrdata0 = mem0[maddr0];
  assign mrdata1 = mem1[maddr1];

  always @(posedge clk) begin
    if (mwe0) begin
      mem0[maddr0] <= mwdata0;
      writes0      <= writes0 + 1;
    end
    if (mwe1) begin
      mem1[maddr1] <= mwdata1;
      writes1      <= writes1 + 1;
    end
  end

  // Route the observed outputs of the instance under test.
  always_comb begin
    if (sel == 0) begin
      s_ready = ready0; s_done = done0; s_err = err0; s_we = mwe0; s_rdata = rdata0;
    end else begin
      s_ready = ready1; s_done = done1; s_err = err1; s_we = mwe1; s_rdata = rdata1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one request from a negedge; returns at the negedge after the
  // accepting edge with the expectation queued.
  task automatic applyStimulus(input int inst, input logic [5:0] o,
                               input logic [31:0] a, input logic [31:0] w,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input int lat);
    exp_t e;
    sel   = inst;
    op    = o;
    addr  = a;
    wdata = w;
    if (inst == 0) req0 = 1'b1; else req1 = 1'b1;
    #1;
    check("ready_before_req", {31'd0, s_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req0 = 1'b0;
    req1 = 1'b0;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = lat;
    sb_q.push_back(e);
  endtask

  // Count edges after the accepting edge until done, then compare against
  // the queued expectation and confirm the pulse is one cycle wide.
  task automatic checkOutput(input string tag);
    exp_t e;
    int   cyc;
    e   = sb_q.pop_front();
    cyc = 0;
    while (s_done !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"},   cyc, e.lat);
    check({tag, "_done"},  {31'd0, s_done}, 32'd1);
    check({tag, "_err"},   {31'd0, s_err}, {31'd0, e.err});
    check({tag, "_rdata"}, s_rdata, e.rdata);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_off"}, {31'd0, s_done}, 32'd0);
    check({tag, "_err_off"},  {31'd0, s_err}, 32'd0);
    check({tag, "_ready"},    {31'd0, s_ready}, 32'd1);
  endtask

  initial begin
    int w_snap;
    int done_seen;

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; op = 6'd0; addr = 32'd0; wdata = 32'd0; sel = 0;
    $display("[TB] start");
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_ready",  {31'd0, ready0}, 32'd1);
    check("rst_done",   {31'd0, done0}, 32'd0);
    check("rst_err",    {31'd0, err0}, 32'd0);
    check("rst_rdata",  rdata0, 32'd0);
    check("rst_we",     {31'd0, mwe0}, 32'd0);
    check("rst_maddr",  {20'd0, maddr0}, 32'd0);
    check("rst_mwdata", {24'd0, mwdata0}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Word store then word load.
    applyStimulus(0, SW, 32'h010, 32'h11223344, 32'h0, 1'b0, 4);
    checkOutput("sw10");
    check("mem10", {24'd0, mem0[12'h010]}, 32'h44);
    check("mem11", {24'd0, mem0[12'h011]}, 32'h33);
    check("mem12", {24'd0, mem0[12'h012]}, 32'h22);
    check("mem13", {24'd0, mem0[12'h013]}, 32'h11);
    applyStimulus(0, LW, 32'h010, 32'h0, 32'h11223344, 1'b0, 4);
    checkOutput("lw10");

    // Byte store, signed and unsigned byte loads.
    applyStimulus(0, SB, 32'h007, 32'h000000AB, 32'h11223344, 1'b0, 1);
    checkOutput("sb07");
    applyStimulus(0, LB, 32'h007, 32'h0, 32'hFFFFFFAB, 1'b0, 1);
    checkOutput("lb07");
    applyStimulus(0, LBU, 32'h007, 32'h0, 32'h000000AB, 1'b0, 1);
    checkOutput("lbu07");

    // Half store next to a marker byte, signed and unsigned half loads.
    applyStimulus(0, SB, 32'h024, 32'h0000005A, 32'h000000AB, 1'b0, 1);
    checkOutput("sb24");
    applyStimulus(0, SH, 32'h022, 32'h12348001, 32'h000000AB, 1'b0, 2);
    checkOutput("sh22");
    check("mem22", {24'd0, mem0[12'h022]}, 32'h01);
    check("mem23", {24'd0, mem0[12'h023]}, 32'h80);
    check("mem24_untouched", {24'd0, mem0[12'h024]}, 32'h5A);
    applyStimulus(0, LH, 32'h022, 32'h0, 32'hFFFF8001, 1'b0, 2);
    checkOutput("lh22");
    applyStimulus(0, LHU, 32'h022, 32'h0, 32'h00008001, 1'b0, 2);
    checkOutput("lhu22");

    // Misaligned and unsupported requests: immediate error, no writes.
    w_snap = writes0;
    applyStimulus(0, LH, 32'h003, 32'h0, 32'h00008001, 1'b1, 0);
    checkOutput("lh03_err");
    applyStimulus(0, SW, 32'h006, 32'hDEADBEEF, 32'h00008001, 1'b1, 0);
    checkOutput("sw06_err");
    applyStimulus(0, 6'h3F, 32'h000, 32'h0, 32'h00008001, 1'b1, 0);
    checkOutput("badop_err");
    check("err_no_writes", writes0 - w_snap, 32'd0);
    check("err_mem06", {24'd0, mem0[12'h022]}, 32'h01);

    // Address wrap on the instance without alignment checking.
    applyStimulus(1, SW, 32'h0FFE, 32'hDDCCBBAA, 32'h0, 1'b0, 4);
    checkOutput("sw_wrap");
    check("memFFE", {24'd0, mem1[12'hFFE]}, 32'hAA);
    check("memFFF", {24'd0, mem1[12'hFFF]}, 32'hBB);
    check("mem000", {24'd0, mem1[12'h000]}, 32'hCC);
    check("mem001", {24'd0, mem1[12'h001]}, 32'hDD);
    applyStimulus(1, LW, 32'h0FFE, 32'h0, 32'hDDCCBBAA, 1'b0, 4);
    checkOutput("lw_wrap");
    applyStimulus(1, LH, 32'h0FFF, 32'h0, 32'hFFFFCCBB, 1'b0, 2);
    checkOutput("lh_wrap");

    // Reset during a word store after two byte writes.
    applyStimulus(0, SW, 32'h040, 32'h00000000, 32'h00008001, 1'b0, 4);
    checkOutput("sw40_clear");
    w_snap = writes0;
    sel   = 0;
    op    = SW;
    addr  = 32'h040;
    wdata = 32'hCAFEBABE;
    req0  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("busy_ready", {31'd0, ready0}, 32'd0);
    op   = LB;
    addr = 32'h100;
    @(posedge clk);
    @(negedge clk);
    req0 = 1'b0;
    rst  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", {31'd0, ready0}, 32'd1);
    check("abort_done",  {31'd0, done0}, 32'd0);
    check("abort_we",    {31'd0, mwe0}, 32'd0);
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done0 === 1'b1) done_seen++;
    end
    check("abort_no_done", done_seen, 32'd0);
    check("abort_writes", writes0 - w_snap, 32'd2);
    check("abort_mem40", {24'd0, mem0[12'h040]}, 32'hBE);
    check("abort_mem41", {24'd0, mem0[12'h041]}, 32'hBA);
    check("abort_mem42", {24'd0, mem0[12'h042]}, 32'h00);
    check("abort_mem43", {24'd0, mem0[12'h043]}, 32'h00);

    // Reset wins over a simultaneous request.
    op   = LW;
    addr = 32'h040;
    req0 = 1'b1;
    rst  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req0 = 1'b0;
    rst  = 1'b0;
    check("rst_prio_ready", {31'd0, ready0}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("rst_prio_done", {31'd0, done0}, 32'd0);

    // Normal operation after the aborted store.
    applyStimulus(0, LW, 32'h040, 32'h0, 32'h0000BABE, 1'b0, 4);
    checkOutput("lw40");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
